// File: rtl/axi_mem_arbiter_pkg.sv
// Shared constants and width helpers for the AXI memory arbiter.
// No logic; elaboration-time functions only.
// Not applicable.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Ceiling log2; 2 -> 1, 3 -> 2, 8 -> 3.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Downstream ID width: upstream ID with the master index prepended.
    function automatic int mid_w(input int id_w, input int num_masters);
        return id_w + clog2(num_masters);
    endfunction

endpackage

// File: rtl/axi_mem_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to first requester at/after the pointer.
// Grant is combinational (0 cycles); pointer moves on the cycle advance is high.
// No backpressure of its own; caller qualifies the grant with its ready.
module rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = clog2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic             found;
    int               idx;

    // Scan from the pointer, wrapping, and grant the first active request.
    always_comb begin
        grant  = '0;
        winner = ptr;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
    end

    // After a handshake the winner drops to lowest priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (winner == PTR_W'(N - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// N-to-1 AXI4 arbiter: RR on AR/AW, W ordered by AW grant, R/B routed by ID prefix.
// AR/AW 1 cycle through a register slice; W, R and B are combinational pass-through.
// Ready is given only to the granted master when its slice can take a beat; AW also stalls on full W-order FIFO.
module axi_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 64,
    parameter  int ID_W        = 6,
    parameter  int WORD_DEPTH  = 4,
    localparam int STRB_W      = DATA_W / 8,
    localparam int IDX_W       = clog2(NUM_MASTERS),
    localparam int MID_W       = mid_w(ID_W, NUM_MASTERS)
) (
    input  logic                                clock,
    input  logic                                reset_n,
    // upstream read address
    input  logic [NUM_MASTERS-1:0]              s_ar_valid,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  s_ar_addr,
    input  logic [NUM_MASTERS-1:0][ID_W-1:0]    s_ar_id,
    input  logic [NUM_MASTERS-1:0][7:0]         s_ar_len,
    input  logic [NUM_MASTERS-1:0][2:0]         s_ar_size,
    input  logic [NUM_MASTERS-1:0][1:0]         s_ar_burst,
    output logic [NUM_MASTERS-1:0]              s_ar_ready,
    // upstream write address
    input  logic [NUM_MASTERS-1:0]              s_aw_valid,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  s_aw_addr,
    input  logic [NUM_MASTERS-1:0][ID_W-1:0]    s_aw_id,
    input  logic [NUM_MASTERS-1:0][7:0]         s_aw_len,
    input  logic [NUM_MASTERS-1:0][2:0]         s_aw_size,
    input  logic [NUM_MASTERS-1:0][1:0]         s_aw_burst,
    output logic [NUM_MASTERS-1:0]              s_aw_ready,
    // upstream write data
    input  logic [NUM_MASTERS-1:0]              s_w_valid,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  s_w_data,
    input  logic [NUM_MASTERS-1:0][STRB_W-1:0]  s_w_strb,
    input  logic [NUM_MASTERS-1:0]              s_w_last,
    output logic [NUM_MASTERS-1:0]              s_w_ready,
    // upstream read data
    output logic [NUM_MASTERS-1:0]              s_r_valid,
    output logic [NUM_MASTERS-1:0][ID_W-1:0]    s_r_id,
    output logic [NUM_MASTERS-1:0][DATA_W-1:0]  s_r_data,
    output logic [NUM_MASTERS-1:0][1:0]         s_r_resp,
    output logic [NUM_MASTERS-1:0]              s_r_last,
    input  logic [NUM_MASTERS-1:0]              s_r_ready,
    // upstream write response
    output logic [NUM_MASTERS-1:0]              s_b_valid,
    output logic [NUM_MASTERS-1:0][ID_W-1:0]    s_b_id,
    output logic [NUM_MASTERS-1:0][1:0]         s_b_resp,
    input  logic [NUM_MASTERS-1:0]              s_b_ready,
    // downstream read address
    output logic                                m_ar_valid,
    output logic [ADDR_W-1:0]                   m_ar_addr,
    output logic [MID_W-1:0]                    m_ar_id,
    output logic [7:0]                          m_ar_len,
    output logic [2:0]                          m_ar_size,
    output logic [1:0]                          m_ar_burst,
    input  logic                                m_ar_ready,
    // downstream write address
    output logic                                m_aw_valid,
    output logic [ADDR_W-1:0]                   m_aw_addr,
    output logic [MID_W-1:0]                    m_aw_id,
    output logic [7:0]                          m_aw_len,
    output logic [2:0]                          m_aw_size,
    output logic [1:0]                          m_aw_burst,
    input  logic                                m_aw_ready,
    // downstream write data
    output logic                                m_w_valid,
    output logic [DATA_W-1:0]                   m_w_data,
    output logic [STRB_W-1:0]                   m_w_strb,
    output logic                                m_w_last,
    input  logic                                m_w_ready,
    // downstream read data
    input  logic                                m_r_valid,
    input  logic [MID_W-1:0]                    m_r_id,
    input  logic [DATA_W-1:0]                   m_r_data,
    input  logic [1:0]                          m_r_resp,
    input  logic                                m_r_last,
    output logic                                m_r_ready,
    // downstream write response
    input  logic                                m_b_valid,
    input  logic [MID_W-1:0]                    m_b_id,
    input  logic [1:0]                          m_b_resp,
    output logic                                m_b_ready,
    // sticky: a response carried an index with no master behind it
    output logic                                decode_err
);

    localparam int PW    = clog2(WORD_DEPTH);
    localparam int CNT_W = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MID_W-1:0]  id;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } addr_req_t;

    logic                   run;
    logic [NUM_MASTERS-1:0] ar_grant, aw_grant, aw_req;
    logic [IDX_W-1:0]       ar_idx, aw_idx;
    logic                   ar_vld_q, aw_vld_q;
    addr_req_t              ar_q, aw_q;
    logic                   ar_free, aw_free, ar_hs, aw_hs;

    logic [IDX_W-1:0]       wq_mem [WORD_DEPTH];
    logic [PW-1:0]          wq_wr, wq_rd;
    logic [CNT_W-1:0]       wq_cnt;
    logic                   wq_full, wq_empty, wq_push, wq_pop;
    logic [IDX_W-1:0]       wq_head;

    logic [IDX_W-1:0]       r_idx, b_idx;
    logic                   r_bad, b_bad;

    // Hold grants off for one cycle after reset_n rises so release is synchronous.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    rr_arbiter #(.N(NUM_MASTERS)) u_ar_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (s_ar_valid),
        .advance (ar_hs),
        .grant   (ar_grant)
    );

    // A full W-order FIFO removes every AW request so no grant is issued.
    assign aw_req = s_aw_valid & {NUM_MASTERS{!wq_full}};

    rr_arbiter #(.N(NUM_MASTERS)) u_aw_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (aw_req),
        .advance (aw_hs),
        .grant   (aw_grant)
    );

    // One-hot grants to master indices.
    always_comb begin
        ar_idx = '0;
        aw_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ar_grant[i]) ar_idx = IDX_W'(i);
            if (aw_grant[i]) aw_idx = IDX_W'(i);
        end
    end

    assign ar_free    = !ar_vld_q || m_ar_ready;
    assign aw_free    = !aw_vld_q || m_aw_ready;
    assign s_ar_ready = (run && ar_free) ? ar_grant : '0;
    assign s_aw_ready = (run && aw_free && !wq_full) ? aw_grant : '0;
    assign ar_hs      = |(s_ar_valid & s_ar_ready);
    assign aw_hs      = |(s_aw_valid & s_aw_ready);

    // AR slice: capture the granted request, tag the ID with its master index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ar_vld_q <= 1'b0;
            ar_q     <= '0;
        end else if (ar_hs) begin
            ar_vld_q <= 1'b1;
            ar_q     <= '{addr:  s_ar_addr[ar_idx],
                          id:    {ar_idx, s_ar_id[ar_idx]},
                          len:   s_ar_len[ar_idx],
                          size:  s_ar_size[ar_idx],
                          burst: s_ar_burst[ar_idx]};
        end else if (m_ar_ready) begin
            ar_vld_q <= 1'b0;
        end
    end

    // AW slice: same as AR.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            aw_vld_q <= 1'b0;
            aw_q     <= '0;
        end else if (aw_hs) begin
            aw_vld_q <= 1'b1;
            aw_q     <= '{addr:  s_aw_addr[aw_idx],
                          id:    {aw_idx, s_aw_id[aw_idx]},
                          len:   s_aw_len[aw_idx],
                          size:  s_aw_size[aw_idx],
                          burst: s_aw_burst[aw_idx]};
        end else if (m_aw_ready) begin
            aw_vld_q <= 1'b0;
        end
    end

    assign m_ar_valid = ar_vld_q;
    assign m_ar_addr  = ar_q.addr;
    assign m_ar_id    = ar_q.id;
    assign m_ar_len   = ar_q.len;
    assign m_ar_size  = ar_q.size;
    assign m_ar_burst = ar_q.burst;

    assign m_aw_valid = aw_vld_q;
    assign m_aw_addr  = aw_q.addr;
    assign m_aw_id    = aw_q.id;
    assign m_aw_len   = aw_q.len;
    assign m_aw_size  = aw_q.size;
    assign m_aw_burst = aw_q.burst;

    // W-order FIFO: master index of each accepted AW, in grant order.
    assign wq_push  = aw_hs;
    assign wq_pop   = m_w_valid && m_w_ready && m_w_last;
    assign wq_full  = (wq_cnt == CNT_W'(WORD_DEPTH));
    assign wq_empty = (wq_cnt == '0);
    assign wq_head  = wq_mem[wq_rd];

    // FIFO storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clock) begin
        if (wq_push) begin
            wq_mem[wq_wr] <= aw_idx;
        end
    end

    // FIFO pointers and occupancy; push with pop leaves the count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wq_wr  <= '0;
            wq_rd  <= '0;
            wq_cnt <= '0;
        end else begin
            if (wq_push) wq_wr <= wq_wr + PW'(1);
            if (wq_pop)  wq_rd <= wq_rd + PW'(1);
            case ({wq_push, wq_pop})
                2'b10:   wq_cnt <= wq_cnt + CNT_W'(1);
                2'b01:   wq_cnt <= wq_cnt - CNT_W'(1);
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    // W beats come only from the master whose burst is at the FIFO head.
    always_comb begin
        m_w_valid = 1'b0;
        m_w_data  = '0;
        m_w_strb  = '0;
        m_w_last  = 1'b0;
        s_w_ready = '0;
        if (!wq_empty) begin
            m_w_valid          = s_w_valid[wq_head];
            m_w_data           = s_w_data[wq_head];
            m_w_strb           = s_w_strb[wq_head];
            m_w_last           = s_w_last[wq_head];
            s_w_ready[wq_head] = m_w_ready;
        end
    end

    assign r_idx = m_r_id[MID_W-1:ID_W];
    assign b_idx = m_b_id[MID_W-1:ID_W];
    assign r_bad = (32'(r_idx) >= NUM_MASTERS);
    assign b_bad = (32'(b_idx) >= NUM_MASTERS);

    // Steer R/B by the ID prefix; undecodable responses are swallowed.
    always_comb begin
        s_r_valid = '0;
        s_b_valid = '0;
        s_r_id    = '0;
        s_r_data  = '0;
        s_r_resp  = '0;
        s_r_last  = '0;
        s_b_id    = '0;
        s_b_resp  = '0;
        m_r_ready = run && r_bad;
        m_b_ready = run && b_bad;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_r_id[i]   = m_r_id[ID_W-1:0];
            s_r_data[i] = m_r_data;
            s_r_resp[i] = m_r_resp;
            s_r_last[i] = m_r_last;
            s_b_id[i]   = m_b_id[ID_W-1:0];
            s_b_resp[i] = m_b_resp;
            if (r_idx == IDX_W'(i)) begin
                s_r_valid[i] = run && m_r_valid;
                m_r_ready    = run && s_r_ready[i];
            end
            if (b_idx == IDX_W'(i)) begin
                s_b_valid[i] = run && m_b_valid;
                m_b_ready    = run && s_b_ready[i];
            end
        end
    end

    // Latch any response that decoded to a missing master.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            decode_err <= 1'b0;
        end else if (run && ((m_r_valid && r_bad) || (m_b_valid && b_bad))) begin
            decode_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter (2-master default plus a 3-master copy for decode errors).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
// Every wait is a fixed number of cycles.
module tb_axi_mem_arbiter;
    import axi_arb_pkg::*;

    localparam int N = 2, AW_W = 32, DW = 64, IW = 6, MW = 7, SW = 8;
    localparam int N3 = 3, MW3 = 8;

    logic clock, reset_n;

    logic [N-1:0]             s_ar_valid, s_ar_ready, s_aw_valid, s_aw_ready;
    logic [N-1:0][AW_W-1:0]   s_ar_addr, s_aw_addr;
    logic [N-1:0][IW-1:0]     s_ar_id, s_aw_id;
    logic [N-1:0][7:0]        s_ar_len, s_aw_len;
    logic [N-1:0][2:0]        s_ar_size, s_aw_size;
    logic [N-1:0][1:0]        s_ar_burst, s_aw_burst;
    logic [N-1:0]             s_w_valid, s_w_last, s_w_ready;
    logic [N-1:0][DW-1:0]     s_w_data;
    logic [N-1:0][SW-1:0]     s_w_strb;
    logic [N-1:0]             s_r_valid, s_r_last, s_r_ready, s_b_valid, s_b_ready;
    logic [N-1:0][IW-1:0]     s_r_id, s_b_id;
    logic [N-1:0][DW-1:0]     s_r_data;
    logic [N-1:0][1:0]        s_r_resp, s_b_resp;
    logic                     m_ar_valid, m_ar_ready, m_aw_valid, m_aw_ready;
    logic [AW_W-1:0]          m_ar_addr, m_aw_addr;
    logic [MW-1:0]            m_ar_id, m_aw_id;
    logic [7:0]               m_ar_len, m_aw_len;
    logic [2:0]               m_ar_size, m_aw_size;
    logic [1:0]               m_ar_burst, m_aw_burst;
    logic                     m_w_valid, m_w_ready, m_w_last;
    logic [DW-1:0]            m_w_data, m_r_data;
    logic [SW-1:0]            m_w_strb;
    logic                     m_r_valid, m_r_ready, m_r_last, m_b_valid, m_b_ready;
    logic [MW-1:0]            m_r_id, m_b_id;
    logic [1:0]               m_r_resp, m_b_resp;
    logic                     decode_err;

    // 3-master instance: only the B path is driven
    logic [N3-1:0]            x_s_ar_ready, x_s_aw_ready, x_s_w_ready;
    logic [N3-1:0]            x_s_r_valid, x_s_r_last, x_s_b_valid, x_s_b_ready;
    logic [N3-1:0][IW-1:0]    x_s_r_id, x_s_b_id;
    logic [N3-1:0][DW-1:0]    x_s_r_data;
    logic [N3-1:0][1:0]       x_s_r_resp, x_s_b_resp;
    logic                     x_m_ar_valid, x_m_aw_valid, x_m_w_valid, x_m_w_last;
    logic [AW_W-1:0]          x_m_ar_addr, x_m_aw_addr;
    logic [MW3-1:0]           x_m_ar_id, x_m_aw_id, x_m_b_id;
    logic [7:0]               x_m_ar_len, x_m_aw_len;
    logic [2:0]               x_m_ar_size, x_m_aw_size;
    logic [1:0]               x_m_ar_burst, x_m_aw_burst;
    logic [DW-1:0]            x_m_w_data;
    logic [SW-1:0]            x_m_w_strb;
    logic                     x_m_r_ready, x_m_b_valid, x_m_b_ready, x_decode_err;

    int n_checks = 0;
    int n_errors = 0;
    int acc;

    logic [MW-1:0] ar_id_exp  [4] = '{7'h11, 7'h62, 7'h11, 7'h62};
    logic [N-1:0]  ar_rdy_exp [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    axi_mem_arbiter u_dut (
        .clock(clock), .reset_n(reset_n),
        .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id), .s_ar_len(s_ar_len),
        .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_ready(s_ar_ready),
        .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id), .s_aw_len(s_aw_len),
        .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_ready(s_aw_ready),
        .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_w_ready(s_w_ready),
        .s_r_valid(s_r_valid), .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .s_r_last(s_r_last), .s_r_ready(s_r_ready),
        .s_b_valid(s_b_valid), .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready),
        .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id), .m_ar_len(m_ar_len),
        .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_ready(m_ar_ready),
        .m_aw_valid(m_aw_valid), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id), .m_aw_len(m_aw_len),
        .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_ready(m_aw_ready),
        .m_w_valid(m_w_valid), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .m_w_ready(m_w_ready),
        .m_r_valid(m_r_valid), .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
        .m_r_last(m_r_last), .m_r_ready(m_r_ready),
        .m_b_valid(m_b_valid), .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_ready(m_b_ready),
        .decode_err(decode_err)
    );

    axi_mem_arbiter #(.NUM_MASTERS(N3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .s_ar_valid('0), .s_ar_addr('0), .s_ar_id('0), .s_ar_len('0),
        .s_ar_size('0), .s_ar_burst('0), .s_ar_ready(x_s_ar_ready),
        .s_aw_valid('0), .s_aw_addr('0), .s_aw_id('0), .s_aw_len('0),
        .s_aw_size('0), .s_aw_burst('0), .s_aw_ready(x_s_aw_ready),
        .s_w_valid('0), .s_w_data('0), .s_w_strb('0), .s_w_last('0), .s_w_ready(x_s_w_ready),
        .s_r_valid(x_s_r_valid), .s_r_id(x_s_r_id), .s_r_data(x_s_r_data), .s_r_resp(x_s_r_resp),
        .s_r_last(x_s_r_last), .s_r_ready('0),
        .s_b_valid(x_s_b_valid), .s_b_id(x_s_b_id), .s_b_resp(x_s_b_resp), .s_b_ready(x_s_b_ready),
        .m_ar_valid(x_m_ar_valid), .m_ar_addr(x_m_ar_addr), .m_ar_id(x_m_ar_id), .m_ar_len(x_m_ar_len),
        .m_ar_size(x_m_ar_size), .m_ar_burst(x_m_ar_burst), .m_ar_ready(1'b0),
        .m_aw_valid(x_m_aw_valid), .m_aw_addr(x_m_aw_addr), .m_aw_id(x_m_aw_id), .m_aw_len(x_m_aw_len),
        .m_aw_size(x_m_aw_size), .m_aw_burst(x_m_aw_burst), .m_aw_ready(1'b0),
        .m_w_valid(x_m_w_valid), .m_w_data(x_m_w_data), .m_w_strb(x_m_w_strb), .m_w_last(x_m_w_last),
        .m_w_ready(1'b0),
        .m_r_valid(1'b0), .m_r_id('0), .m_r_data('0), .m_r_resp('0), .m_r_last(1'b0),
        .m_r_ready(x_m_r_ready),
        .m_b_valid(x_m_b_valid), .m_b_id(x_m_b_id), .m_b_resp(2'b00), .m_b_ready(x_m_b_ready),
        .decode_err(x_decode_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        s_ar_valid = '0; s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0; s_ar_size = '0; s_ar_burst = '0;
        s_aw_valid = '0; s_aw_addr = '0; s_aw_id = '0; s_aw_len = '0; s_aw_size = '0; s_aw_burst = '0;
        s_w_valid = '0; s_w_data = '0; s_w_strb = '0; s_w_last = '0;
        s_r_ready = '0; s_b_ready = '0;
        m_ar_ready = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
        m_r_valid = 1'b0; m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0;
        m_b_valid = 1'b0; m_b_id = '0; m_b_resp = '0;
        x_m_b_valid = 1'b0; x_m_b_id = '0; x_s_b_ready = '0;

        // ---- reset: requests present but nothing may be accepted or driven
        s_ar_valid = 2'b11;
        s_ar_id[0] = 6'h11; s_ar_id[1] = 6'h22;
        s_ar_burst[0] = BURST_INCR; s_ar_burst[1] = BURST_INCR;
        repeat (2) step();
        check_eq("rst_s_ar_ready", 64'(s_ar_ready), 64'h0);
        check_eq("rst_m_ar_valid", 64'(m_ar_valid), 64'h0);
        check_eq("rst_m_w_valid",  64'(m_w_valid),  64'h0);
        check_eq("rst_decode_err", 64'(decode_err), 64'h0);
        reset_n = 1'b1;
        #1;
        check_eq("rel_no_grant_yet", 64'(s_ar_ready), 64'h0);
        step();

        // ---- AR round-robin alternation 0,1,0,1
        m_ar_ready = 1'b1;
        #1;
        check_eq("ar_first_grant", 64'(s_ar_ready), 64'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("ar_alt_valid", 64'(m_ar_valid), 64'h1);
            check_eq("ar_alt_id",    64'(m_ar_id),    64'(ar_id_exp[k]));
            check_eq("ar_alt_ready", 64'(s_ar_ready), 64'(ar_rdy_exp[k]));
        end
        m_ar_ready = 1'b0;
        #1;
        check_eq("ar_stall_ready", 64'(s_ar_ready), 64'h0);
        step();
        check_eq("ar_hold_id",    64'(m_ar_id),    64'h62);
        check_eq("ar_hold_valid", 64'(m_ar_valid), 64'h1);
        s_ar_valid = '0;
        m_ar_ready = 1'b1;
        step();
        check_eq("ar_drained", 64'(m_ar_valid), 64'h0);

        // ---- W ordering: m1 len=3 then m0 len=0
        m_aw_ready = 1'b1;
        s_aw_valid = 2'b10; s_aw_len[1] = 8'd3; s_aw_id[1] = 6'h03;
        #1;
        check_eq("aw_m1_ready", 64'(s_aw_ready), 64'h2);
        step();
        check_eq("aw_m1_id",  64'(m_aw_id),  64'h43);
        check_eq("aw_m1_len", 64'(m_aw_len), 64'h3);
        s_aw_valid = 2'b01; s_aw_len[0] = 8'd0; s_aw_id[0] = 6'h04;
        #1;
        check_eq("aw_m0_ready", 64'(s_aw_ready), 64'h1);
        step();
        check_eq("aw_m0_id", 64'(m_aw_id), 64'h04);
        s_aw_valid = '0;
        m_w_ready = 1'b1;
        s_w_valid = 2'b11;
        s_w_data[0] = 64'hA0; s_w_last[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            s_w_data[1] = 64'hB0 + 64'(j);
            s_w_last[1] = (j == 3);
            #1;
            check_eq("w_m1_data",  64'(m_w_data),  64'hB0 + 64'(j));
            check_eq("w_m1_ready", 64'(s_w_ready), 64'h2);
            check_eq("w_m1_last",  64'(m_w_last),  (j == 3) ? 64'h1 : 64'h0);
            step();
        end
        #1;
        check_eq("w_m0_data",  64'(m_w_data),  64'hA0);
        check_eq("w_m0_ready", 64'(s_w_ready), 64'h1);
        step();
        check_eq("w_empty_valid", 64'(m_w_valid), 64'h0);
        check_eq("w_empty_ready", 64'(s_w_ready), 64'h0);
        s_w_valid = '0; s_w_last = '0;
        m_w_ready = 1'b0;

        // ---- response routing
        m_r_valid = 1'b1; m_r_id = 7'b1_000101; m_r_data = 64'hDEAD; m_r_last = 1'b1;
        s_r_ready = 2'b10;
        #1;
        check_eq("r_valid",   64'(s_r_valid),   64'h2);
        check_eq("r_id1",     64'(s_r_id[1]),   64'h5);
        check_eq("r_data1",   64'(s_r_data[1]), 64'hDEAD);
        check_eq("r_m_ready", 64'(m_r_ready),   64'h1);
        s_r_ready = 2'b01;
        #1;
        check_eq("r_m_ready_bp", 64'(m_r_ready), 64'h0);
        m_r_valid = 1'b0;
        m_b_valid = 1'b1; m_b_id = 7'h09; s_b_ready = 2'b01;
        #1;
        check_eq("b_valid",   64'(s_b_valid), 64'h1);
        check_eq("b_id0",     64'(s_b_id[0]), 64'h9);
        check_eq("b_m_ready", 64'(m_b_ready), 64'h1);
        m_b_valid = 1'b0;
        step();
        check_eq("no_decode_err", 64'(decode_err), 64'h0);

        // ---- W-order FIFO fills at 4 with m_w_ready low
        s_aw_len = '0;
        s_aw_valid = 2'b11;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            acc += $countones(s_aw_valid & s_aw_ready);
            step();
        end
        check_eq("fifo_accepted", 64'(acc), 64'h4);
        #1;
        check_eq("fifo_full_ready", 64'(s_aw_ready), 64'h0);
        s_w_valid = 2'b11; s_w_last = 2'b11; m_w_ready = 1'b1;
        #1;
        check_eq("fifo_pop_cycle_ready", 64'(s_aw_ready), 64'h0);
        check_eq("fifo_head_valid",      64'(m_w_valid),  64'h1);
        step();
        m_w_ready = 1'b0;
        #1;
        check_eq("fifo_after_pop_ready", 64'(s_aw_ready), 64'h2);

        // ---- reset mid-burst
        check_eq("pre_rst_w_valid", 64'(m_w_valid), 64'h1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_m_w_valid",  64'(m_w_valid),  64'h0);
        check_eq("midrst_m_aw_valid", 64'(m_aw_valid), 64'h0);
        check_eq("midrst_s_aw_ready", 64'(s_aw_ready), 64'h0);
        check_eq("midrst_s_w_ready",  64'(s_w_ready),  64'h0);
        step();
        reset_n = 1'b1;
        s_ar_valid = 2'b11;
        #1;
        check_eq("midrst_rel_ready", 64'(s_aw_ready), 64'h0);
        step();
        check_eq("post_rst_aw_grant", 64'(s_aw_ready), 64'h1);
        check_eq("post_rst_ar_grant", 64'(s_ar_ready), 64'h1);
        check_eq("post_rst_w_empty",  64'(m_w_valid),  64'h0);
        s_ar_valid = '0; s_aw_valid = '0; s_w_valid = '0;

        // ---- 3-master: index 3 is undecodable
        x_m_b_valid = 1'b1; x_m_b_id = 8'b11_000001; x_s_b_ready = 3'b111;
        #1;
        check_eq("dec_m_b_ready", 64'(x_m_b_ready),  64'h1);
        check_eq("dec_no_s_b",    64'(x_s_b_valid),  64'h0);
        check_eq("dec_err_before",64'(x_decode_err), 64'h0);
        step();
        x_m_b_valid = 1'b0;
        #1;
        check_eq("dec_err_set", 64'(x_decode_err), 64'h1);
        step();
        check_eq("dec_err_sticky", 64'(x_decode_err), 64'h1);
        x_m_b_valid = 1'b1; x_m_b_id = 8'b10_000111; x_s_b_ready = 3'b011;
        #1;
        check_eq("m2_s_b_valid", 64'(x_s_b_valid), 64'h4);
        check_eq("m2_s_b_id",    64'(x_s_b_id[2]), 64'h7);
        check_eq("m2_m_b_ready", 64'(x_m_b_ready), 64'h0);
        x_m_b_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of upstream AXI4 masters (legal range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 64, data width; STRB_W = DATA_W/8.
REQ-004 SHALL have parameter ID_W, default 6, upstream ID width; MID_W = ID_W + clog2(NUM_MASTERS) downstream.
REQ-005 SHALL have parameter WORD_DEPTH, default 4, W-order FIFO depth (power of 2).
REQ-006 SHALL have ports: clock  in  1  sole clock, all logic rising-edge.
REQ-007 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: s_ar_{valid,addr,id,len,size,burst}  in  NUM_MASTERS x {1,ADDR_W,ID_W,8,3,2}  upstream read address.
REQ-009 SHALL have ports: s_ar_ready  out  NUM_MASTERS  per-master accept.
REQ-010 SHALL have ports: s_aw_* / s_aw_ready  as REQ-008/009  upstream write address.
REQ-011 SHALL have ports: s_w_{valid,data,strb,last} in, s_w_ready out  NUM_MASTERS x {1,DATA_W,STRB_W,1}  upstream write data.
REQ-012 SHALL have ports: s_r_{valid,id,data,resp,last} out, s_r_ready in; s_b_{valid,id,resp} out, s_b_ready in  per master.
REQ-013 SHALL have ports: m_ar_*, m_aw_*, m_w_*, m_r_*, m_b_*  one downstream AXI4 master port, IDs MID_W wide.
REQ-014 SHALL have ports: decode_err  out  1  sticky, response ID decoded to master index >= NUM_MASTERS.

Function
REQ-015 SHALL arbitrate AR and AW independently, round-robin; priority pointer starts at master 0 and moves to winner+1 after each handshake.
REQ-016 SHALL forward each granted AR/AW through a one-entry register slice: 1-cycle latency from s handshake to m_valid.
REQ-017 SHALL assert s_x_ready only to the granted master, and only when its slice is empty or is draining (m_x_ready) that cycle.
REQ-018 SHALL hold m_x_valid and its payload stable until m_x_ready.
REQ-019 SHALL drive m_x_id = {master_index, s_x_id}.
REQ-020 SHALL push the granted master index into the W-order FIFO on each AW handshake; no AW grant is issued while the FIFO is full.
REQ-021 SHALL route W beats combinationally from the master at the FIFO head; pop on m_w handshake with last=1; with the FIFO empty, m_w_valid=0 and all s_w_ready=0.
REQ-022 SHALL, on push and pop in the same cycle, keep occupancy unchanged, including when full.
REQ-023 SHALL route R/B to the master selected by id[MID_W-1:ID_W], strip that field, and pass ready back combinationally (0 extra latency).
REQ-024 SHALL accept and discard (m_ready=1) any response whose index >= NUM_MASTERS and set decode_err until reset.
REQ-025 SHALL not reorder beats within a burst and shall not split or merge bursts.

Reset
REQ-026 SHALL, while reset_n=0, force all valid outputs, all s_*_ready, and decode_err to 0, both RR pointers to 0, and the FIFO to empty.
REQ-027 SHALL abandon in-flight bursts on reset mid-operation; no recovery state survives.
REQ-028 SHALL release reset synchronously; the first grant is possible one cycle after reset_n rises.

Structure
REQ-029 SHALL place MID_W computation, the clog2 function, and AXI burst/resp constants in shared package axi_arb_pkg.
REQ-030 SHALL instantiate sub-module rr_arbiter (parametrised N, request vector, advance strobe, one-hot grant) once for AR and once for AW.
REQ-031 SHALL implement the W-order FIFO and register slices inline.

Verification
REQ-032 SHALL cover: masters 0,1 both hold AR continuously, m_ar_ready=1 -> m_ar grants alternate 0,1,0,1; m_ar_id[6] toggles.
REQ-033 SHALL cover: m1 AW len=3 then m0 AW len=0 -> m_w carries m1's 4 beats then m0's 1 beat; s0_w_ready=0 until m1 last pops.
REQ-034 SHALL cover: WORD_DEPTH=4, m_w_ready=0, 5 AWs offered -> 4 accepted, 5th s_aw_ready stays 0 until one W last completes.
REQ-035 SHALL cover: m_r beat with id=7'b1_000101 -> s_r_valid[1]=1, s_r_id[1]=6'd5, s_r_valid[0]=0.
REQ-036 SHALL cover: NUM_MASTERS=3, m_b id index=3 -> m_b_ready=1, no s_b_valid, decode_err=1 thereafter.
REQ-037 SHALL cover: reset_n pulsed low mid-burst -> all valids 0 immediately, FIFO empty, next grant to master 0.
